// File: rtl/frame_boundary_inserter.sv
// Wraps each SC16 payload packet into a frame: zero gap, periodic +/-amp preamble, payload.
// Optional FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN appends a zero trailer of gap_len samples.
module frame_boundary_inserter #(
    parameter int unsigned PERIOD = 16,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned REPS_W = 8
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              clear,
    input  logic [GAP_W-1:0]  cfg_gap_len,
    input  logic [REPS_W-1:0] cfg_reps,
    input  logic [15:0]       cfg_amp,
    input  logic [31:0]       i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [31:0]       o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              busy,
    output logic [31:0]       frame_count
);
    localparam int unsigned LOG2P = $clog2(PERIOD);
    localparam int unsigned PRE_W = REPS_W + LOG2P;

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_PRE, S_PAY, S_TRAIL} state_t;

    state_t            state, state_nxt;
    logic [GAP_W-1:0]  gap_len_q, gap_cnt;
    logic [REPS_W-1:0] reps_q;
    logic [15:0]       amp_q;
    logic [PRE_W-1:0]  pre_cnt;

    logic        rst_c, adv_c, pay_take_c, gap_last_c, pre_last_c;
    logic [15:0] pre_i_c;
    logic        emit_c, emit_last_c, fc_inc_c, gap_inc_c, pre_inc_c, latch_c;
    logic [31:0] emit_data_c;

    assign rst_c      = ce_rst || clear;
    assign adv_c      = !o_tvalid || o_tready;
    assign pay_take_c = (state == S_PAY) && adv_c && i_tvalid;
    assign gap_last_c = (gap_cnt == gap_len_q - GAP_W'(1));
    assign pre_last_c = (pre_cnt == {reps_q, {LOG2P{1'b0}}} - PRE_W'(1));
    // First half of each period is +amp, second half is -amp (16-bit wrap).
    assign pre_i_c    = pre_cnt[LOG2P-1] ? 16'(~amp_q + 16'd1) : amp_q;
    assign busy       = (state != S_IDLE);

`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
    logic trail_c;
    assign trail_c = (gap_len_q != '0);
`endif

    always_ff @(posedge ce_clk) begin
        if (rst_c) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_tvalid) begin
                    if (cfg_gap_len != '0)   state_nxt = S_GAP;
                    else if (cfg_reps != '0) state_nxt = S_PRE;
                    else                     state_nxt = S_PAY;
                end
            end
            S_GAP:   if (adv_c && gap_last_c) state_nxt = (reps_q != '0) ? S_PRE : S_PAY;
            S_PRE:   if (adv_c && pre_last_c) state_nxt = S_PAY;
            S_PAY: begin
                if (pay_take_c && i_tlast) begin
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
                    state_nxt = trail_c ? S_TRAIL : S_IDLE;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_TRAIL: if (adv_c && gap_last_c) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        emit_c      = 1'b0;
        emit_data_c = '0;
        emit_last_c = 1'b0;
        i_tready    = 1'b0;
        fc_inc_c    = 1'b0;
        gap_inc_c   = 1'b0;
        pre_inc_c   = 1'b0;
        latch_c     = 1'b0;
        unique case (state)
            S_IDLE: latch_c = i_tvalid;
            S_GAP: begin
                emit_c    = adv_c;
                gap_inc_c = adv_c;
            end
            S_PRE: begin
                emit_c      = adv_c;
                pre_inc_c   = adv_c;
                emit_data_c = {pre_i_c, 16'h0000};
            end
            S_PAY: begin
                i_tready    = adv_c;
                emit_c      = pay_take_c;
                emit_data_c = i_tdata;
                emit_last_c = i_tlast;
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
                if (trail_c) emit_last_c = 1'b0;
                fc_inc_c = pay_take_c && i_tlast && !trail_c;
`else
                fc_inc_c = pay_take_c && i_tlast;
`endif
            end
            S_TRAIL: begin
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
                emit_c      = adv_c;
                gap_inc_c   = adv_c;
                emit_last_c = gap_last_c;
                fc_inc_c    = adv_c && gap_last_c;
`endif
            end
            default: ;
        endcase
    end

    // Config latch, sample counters, output register and frame counter.
    always_ff @(posedge ce_clk) begin
        if (rst_c) begin
            gap_len_q   <= '0;
            reps_q      <= '0;
            amp_q       <= '0;
            gap_cnt     <= '0;
            pre_cnt     <= '0;
            o_tvalid    <= 1'b0;
            o_tdata     <= '0;
            o_tlast     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (latch_c) begin
                gap_len_q <= cfg_gap_len;
                reps_q    <= cfg_reps;
                amp_q     <= cfg_amp;
                gap_cnt   <= '0;
                pre_cnt   <= '0;
            end
            if (gap_inc_c) gap_cnt <= gap_last_c ? '0 : gap_cnt + GAP_W'(1);
            if (pre_inc_c) pre_cnt <= pre_last_c ? '0 : pre_cnt + PRE_W'(1);
            if (adv_c) o_tvalid <= emit_c;
            if (emit_c) begin
                o_tdata <= emit_data_c;
                o_tlast <= emit_last_c;
            end
            if (fc_inc_c) frame_count <= frame_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_frame_boundary_inserter.sv
// Directed bench for frame_boundary_inserter; trailer test runs when
// FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN is defined.
module tb_frame_boundary_inserter;
    localparam int unsigned PERIOD = 16;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] cfg_gap_len = '0;
    logic [7:0]  cfg_reps = '0;
    logic [15:0] cfg_amp = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        busy;
    logic [31:0] frame_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    frame_boundary_inserter #(.PERIOD(PERIOD), .GAP_W(16), .REPS_W(8)) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear),
        .cfg_gap_len(cfg_gap_len), .cfg_reps(cfg_reps), .cfg_amp(cfg_amp),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 ce_clk = ~ce_clk;

    // Output monitor: records accepted beats and checks hold-while-stalled.
    always @(negedge ce_clk) begin
        if (prev_stall) begin
            checks++;
            if (!o_tvalid || {o_tlast, o_tdata} !== prev_beat) begin
                errors++;
                $display("FAIL stall_hold: got v=%b %h, expected v=1 %h", o_tvalid, {o_tlast, o_tdata}, prev_beat);
            end
        end
        prev_stall = o_tvalid && !o_tready && !ce_rst && !clear;
        prev_beat  = {o_tlast, o_tdata};
        if (o_tvalid && o_tready && !ce_rst && !clear) out_q.push_back({o_tlast, o_tdata});
    end

    task automatic do_reset();
        @(posedge ce_clk); #1;
        ce_rst = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
        repeat (2) @(posedge ce_clk);
        #1 ce_rst = 1'b0;
        out_q.delete();
        exp_q.delete();
    endtask

    // Independent frame model appended to exp_q.
    task automatic add_frame(input int gap, input int reps, input logic [15:0] amp, input logic [31:0] pay[$]);
        logic [15:0] iv;
        logic        last;
        for (int i = 0; i < gap; i++) exp_q.push_back({1'b0, 32'h0});
        for (int k = 0; k < reps * int'(PERIOD); k++) begin
            iv = ((k % PERIOD) < (PERIOD / 2)) ? amp : 16'(16'h0000 - amp);
            exp_q.push_back({1'b0, iv, 16'h0000});
        end
        for (int j = 0; j < pay.size(); j++) begin
            last = (j == pay.size() - 1);
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
            if (gap != 0) last = 1'b0;
`endif
            exp_q.push_back({last, pay[j]});
        end
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
        for (int i = 0; i < gap; i++) exp_q.push_back({(i == gap - 1), 32'h0});
`endif
    endtask

    task automatic send_pkt(input logic [31:0] pay[$]);
        int cyc;
        @(posedge ce_clk); #1;
        for (int i = 0; i < pay.size(); i++) begin
            i_tvalid = 1'b1;
            i_tdata  = pay[i];
            i_tlast  = (i == pay.size() - 1);
            cyc = 0;
            @(negedge ce_clk);
            while (!i_tready && cyc < 500) begin
                @(negedge ce_clk);
                cyc++;
            end
            if (!i_tready) begin
                errors++;
                $display("FAIL send_timeout: beat %0d got i_tready=0, expected 1", i);
                i_tvalid = 1'b0;
                return;
            end
            @(posedge ce_clk); #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int cyc = 0;
        while (out_q.size() < n && cyc < 3000) begin
            @(negedge ce_clk);
            cyc++;
        end
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL wait_out: got %0d beats, expected %0d", out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge ce_clk);
        checks++;
        if ({o_tvalid, o_tlast, i_tready, busy} !== 4'b0000 || o_tdata !== 32'h0 || frame_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got v%b l%b r%b b%b d=%h fc=%0d, expected all zero",
                     o_tvalid, o_tlast, i_tready, busy, o_tdata, frame_count);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] pay[$];
        pay = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        do_reset();
        cfg_gap_len = 16'd3; cfg_reps = 8'd2; cfg_amp = 16'h1000;
        add_frame(3, 2, 16'h1000, pay);
        send_pkt(pay);
        wait_out(exp_q.size());
        repeat (4) @(negedge ce_clk);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_len: got %0d, expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
            end
        end
`ifndef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
        checks++;
        if (out_q.size() != 39 || out_q[3] !== {1'b0, 32'h10000000} || out_q[11] !== {1'b0, 32'hF0000000}
            || out_q[38] !== {1'b1, 32'hDDDD0004}) begin
            errors++;
            $display("FAIL basic_hand: got n=%0d b3=%h b11=%h, expected 39 010000000 0F0000000 1DDDD0004",
                     out_q.size(), out_q[3], out_q[11]);
        end
`endif
        checks++;
        if (frame_count !== 32'd1) begin
            errors++;
            $display("FAIL basic_fc: got %0d, expected 1", frame_count);
        end
    endtask

    task automatic test_passthrough();
        do_reset();
        cfg_gap_len = 16'd0; cfg_reps = 8'd0;
        @(posedge ce_clk); #1;
        i_tvalid = 1'b1; i_tdata = 32'h12345678; i_tlast = 1'b1;
        @(negedge ce_clk);
        checks++;
        if (i_tready !== 1'b0) begin
            errors++;
            $display("FAIL pass_idle_ready: got %b, expected 0", i_tready);
        end
        @(negedge ce_clk);
        checks++;
        if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pass_pay_ready: got r=%b v=%b, expected r=1 v=0", i_tready, o_tvalid);
        end
        @(posedge ce_clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        @(negedge ce_clk);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'h12345678 || o_tlast !== 1'b1 || frame_count !== 32'd1) begin
            errors++;
            $display("FAIL pass_out: got v%b %h l%b fc=%0d, expected v1 12345678 l1 fc=1",
                     o_tvalid, o_tdata, o_tlast, frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pay[$];
        bit done = 0;
        pay = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004, 32'h55550005};
        do_reset();
        cfg_gap_len = 16'd2; cfg_reps = 8'd1; cfg_amp = 16'h0123;
        add_frame(2, 1, 16'h0123, pay);
        fork
            begin
                send_pkt(pay);
                done = 1;
            end
            begin
                int cyc = 0;
                while (!done && cyc < 2000) begin
                    @(posedge ce_clk); #1;
                    o_tready = 1'($urandom_range(0, 1));
                    cyc++;
                end
            end
        join
        @(posedge ce_clk); #1 o_tready = 1'b1;
        wait_out(exp_q.size());
        repeat (4) @(negedge ce_clk);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d, expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
            end
        end
        checks++;
        if (frame_count !== 32'd1) begin
            errors++;
            $display("FAIL bp_fc: got %0d, expected 1", frame_count);
        end
    endtask

    task automatic test_amp_wrap();
        logic [31:0] pay[$];
        pay = '{32'h00000001};
        do_reset();
        cfg_gap_len = 16'd0; cfg_reps = 8'd1; cfg_amp = 16'h8000;
        add_frame(0, 1, 16'h8000, pay);
        send_pkt(pay);
        wait_out(exp_q.size());
        repeat (2) @(negedge ce_clk);
        checks++;
        if (out_q.size() < 17 || out_q[0] !== {1'b0, 32'h80000000} || out_q[8] !== {1'b0, 32'h80000000}) begin
            errors++;
            $display("FAIL amp_wrap: got n=%0d b0=%h b8=%h, expected 17 080000000 080000000",
                     out_q.size(), out_q[0], out_q[8]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL amp_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] pay[$];
        pay = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
        do_reset();
        cfg_gap_len = 16'd3; cfg_reps = 8'd2; cfg_amp = 16'h1000;
        @(posedge ce_clk); #1;
        i_tvalid = 1'b1; i_tdata = pay[0]; i_tlast = 1'b0;
        wait_out(5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b, expected 1", busy);
        end
        @(posedge ce_clk); #1;
        ce_rst = 1'b1; i_tvalid = 1'b0;
        @(posedge ce_clk); #1;
        ce_rst = 1'b0;
        @(negedge ce_clk);
        checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 32'd0) begin
            errors++;
            $display("FAIL midrst_state: got v%b b%b fc=%0d, expected v0 b0 fc=0", o_tvalid, busy, frame_count);
        end
        out_q.delete();
        exp_q.delete();
        add_frame(3, 2, 16'h1000, pay);
        send_pkt(pay);
        wait_out(exp_q.size());
        repeat (3) @(negedge ce_clk);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_len: got %0d, expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
            end
        end
        checks++;
        if (frame_count !== 32'd1) begin
            errors++;
            $display("FAIL midrst_fc: got %0d, expected 1", frame_count);
        end
        // clear mid-frame behaves like reset
        @(posedge ce_clk); #1;
        i_tvalid = 1'b1; i_tdata = pay[0];
        repeat (3) @(posedge ce_clk);
        #1 clear = 1'b1; i_tvalid = 1'b0;
        @(posedge ce_clk); #1 clear = 1'b0;
        @(negedge ce_clk);
        checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 32'd0) begin
            errors++;
            $display("FAIL clear_state: got v%b b%b fc=%0d, expected v0 b0 fc=0", o_tvalid, busy, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p1[$];
        logic [31:0] p2[$];
        p1 = '{32'h01010101, 32'h02020202};
        p2 = '{32'h03030303, 32'h04040404, 32'h05050505};
        do_reset();
        cfg_gap_len = 16'd1; cfg_reps = 8'd1; cfg_amp = 16'h0200;
        add_frame(1, 1, 16'h0200, p1);
        add_frame(1, 1, 16'h0200, p2);
        send_pkt(p1);
        send_pkt(p2);
        wait_out(exp_q.size());
        repeat (4) @(negedge ce_clk);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d, expected %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, exp_q[i]);
            end
        end
        checks++;
        if (frame_count !== 32'd2) begin
            errors++;
            $display("FAIL b2b_fc: got %0d, expected 2", frame_count);
        end
    endtask

`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
    task automatic test_trailer();
        logic [31:0] pay[$];
        logic [32:0] hand[$];
        pay  = '{32'h0000AAAA, 32'h0000BBBB};
        hand = '{33'h0_00000000, 33'h0_00000000, 33'h0_0000AAAA, 33'h0_0000BBBB, 33'h0_00000000, 33'h1_00000000};
        do_reset();
        cfg_gap_len = 16'd2; cfg_reps = 8'd0;
        send_pkt(pay);
        wait_out(5);
        checks++;
        if (frame_count !== 32'd0) begin
            errors++;
            $display("FAIL trail_fc_early: got %0d, expected 0", frame_count);
        end
        wait_out(6);
        checks++;
        if (frame_count !== 32'd1) begin
            errors++;
            $display("FAIL trail_fc: got %0d, expected 1", frame_count);
        end
        repeat (3) @(negedge ce_clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== hand[i]) begin
                errors++;
                $display("FAIL trail_beat%0d: got %h, expected %h", i, (i < out_q.size()) ? out_q[i] : 33'h0, hand[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_passthrough();
        test_backpressure();
        test_amp_wrap();
        test_mid_reset();
        test_back_to_back();
`ifdef FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
        test_trailer();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_boundary_inserter.md
Name: frame_boundary_inserter

Overview:
- Transmit-side counterpart of the boundary detector. Takes SC16 payload packets and wraps each one into an over-the-air frame.
- Frame layout: a gap of zero samples, then a periodic training preamble, then the payload.
- The receiver's delay-and-correlate detector, with DELAY = PERIOD, finds the frame boundary from the preamble.
- Sits between the axi_wrapper m_axis_data and s_axis_data ports of its own RFNoC block. Settings registers feed the cfg_* ports.

Parameters:
- PERIOD, 16: preamble repetition period in samples. Power of two, 4..256.
- GAP_W, 16: width of the gap-length config.
- REPS_W, 8: width of the preamble-repetition config.

Ports:
- ce_clk  in  1  block clock
- ce_rst  in  1  synchronous active-high reset
- clear  in  1  synchronous flush (clear_tx_seqnum); same effect as ce_rst
- cfg_gap_len  in  GAP_W  zero samples before the preamble
- cfg_reps  in  REPS_W  number of preamble periods
- cfg_amp  in  16  preamble amplitude (signed)
- i_tdata  in  32  payload sample {I[31:16],Q[15:0]}
- i_tlast  in  1  end of payload packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  32  framed output sample
- o_tlast  out  1  end of frame
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- busy  out  1  high when state is not IDLE
- frame_count  out  32  frames completed, wraps modulo 2^32

Behaviour:
- Reset (ce_rst or clear, synchronous):
  - state = IDLE; o_tvalid = 0; o_tdata = 0; o_tlast = 0; i_tready = 0; busy = 0; frame_count = 0; all counters = 0.
- Output stage:
  - Single registered stage; advances when adv = !o_tvalid || o_tready.
  - o_tdata and o_tlast hold stable while o_tvalid && !o_tready.
- States:
  - IDLE → latch gap_len, reps and amp in the cycle i_tvalid is first seen high. Next state is GAP if gap_len ≠ 0, else PRE if reps ≠ 0, else PAY. No output in that cycle.
  - GAP → emit 32'h0 on each adv, gap_len samples total. After the last one, go to PRE (reps ≠ 0) or PAY.
  - PRE → emit sample k on each adv, k = 0..reps*PERIOD-1:
    - I = amp when (k mod PERIOD) < PERIOD/2, else -amp (two's complement, 16-bit wrap; amp = 16'h8000 stays 8000).
    - Q = 0.
    - After the last sample, go to PAY.
  - PAY → i_tready = adv. Each accepted input is copied to the output register.
    - o_tlast = i_tlast on the accepted beat.
    - On an accepted i_tlast: frame_count += 1, state = IDLE.
- i_tready is 0 in every state except PAY. Payload latency is 1 cycle, input handshake to o_tvalid.
- A frame always ends with o_tlast on the payload's last sample (see the optional feature for the exception). The gap and preamble never assert o_tlast.
- cfg_* changes mid-frame have no effect; they take effect at the next IDLE latch.
- gap_len = 0 and reps = 0: block is a 1-cycle pass-through, except for the single IDLE cycle at the start of each packet.
- Back-to-back packets: every packet gets its own gap and preamble. The IDLE cycle costs one bubble.
- Reset or clear mid-frame: the partial frame is abandoned and the output is dropped immediately. Remaining input beats of that packet are treated as a new packet.
- Counter widths:
  - Gap counter: GAP_W bits.
  - Preamble counter: REPS_W + log2(PERIOD) bits, so no overflow at maximum reps.

Optional Feature:
- Macro: FRAME_BOUNDARY_INSERTER_TRAILER_GAP_EN
- Defined:
  - Adds state TRAIL after PAY, entered when gap_len ≠ 0.
  - On the payload's last beat, o_tlast is forced 0.
  - TRAIL then emits gap_len zeros; the last zero carries o_tlast = 1.
  - frame_count increments on the last trailer beat and state returns to IDLE.
  - With gap_len = 0, behaviour is identical to the undefined case.
- Undefined: no TRAIL state; the frame ends on the payload's tlast.

Test Plan:
- gap = 3, reps = 2, PERIOD = 16, amp = 16'h1000, 4-sample payload A..D (D tlast), o_tready = 1:
  - 3×00000000, then 2× [8×10000000, 8×F0000000], then A, B, C, D.
  - o_tlast only on D; frame_count = 1; 39 output beats.
- gap = 0, reps = 0, 1-sample packet with tlast, value 12345678:
  - o_tdata = 12345678 and o_tlast = 1, one cycle after the input handshake.
  - i_tready low during the IDLE cycle.
- gap = 2, reps = 1, o_tready toggled randomly (50%):
  - Output sequence identical to the o_tready = 1 run.
  - o_tdata and o_tlast stable whenever o_tvalid && !o_tready; no payload beat dropped or duplicated.
- amp = 16'h8000, reps = 1: first-half I = 8000, second-half I = 8000 (wrap). Q always 0.
- ce_rst asserted for one cycle during the PRE state of frame 1:
  - Next cycle o_tvalid = 0, busy = 0, frame_count = 0.
  - Re-sent packet produces a full gap + preamble + payload frame.
- TRAILER_GAP_EN defined, gap = 2, reps = 0, payload X, Y (Y tlast):
  - Output: 0, 0, X, Y, 0, 0(tlast).
  - frame_count increments on the final zero beat only.
